// File: rtl/arf_stack_sequencer.sv
// arf_stack_sequencer: command-driven sequencer for the PC/AR/SP address register
// file. Drives FunSel/RegSel/OutCSel/OutDSel/ISel and the memory strobes to carry
// out FETCH, PUSH, POP, CALL, RET and LOADAR, keeping an internal stack depth.
//
// state      | meaning
// -----------+----------------------------------------------------------
// st_idle    | ready for a command; rejected commands pulse Error here
// st_fetch   | read memory at PC; PC increments on the MemReady edge
// st_push_w  | write AR to memory at SP, held until MemReady
// st_push_d  | SP decrements, depth grows
// st_pop_i   | SP increments, depth shrinks
// st_pop_r   | read memory at SP; AR loads it on the MemReady edge
// st_call_w  | write PC to memory at SP, held until MemReady
// st_call_d  | SP decrements, depth grows
// st_call_j  | PC loads the latched target
// st_ret_i   | SP increments, depth shrinks
// st_ret_r   | read memory at SP; PC loads it on the MemReady edge
// st_loadar  | AR loads the latched target
// st_done    | one-cycle Done pulse, then back to idle
module arf_stack_sequencer #(
    parameter int         MaxDepth = 16,
    parameter int         DepthW   = 5,
    parameter logic [2:0] FsDec    = 3'b000,
    parameter logic [2:0] FsInc    = 3'b001,
    parameter logic [2:0] FsLoad   = 3'b010
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        Cmd,
    input  logic [15:0]       Target,
    input  logic              MemReady,
    output logic [2:0]        ArfFunSel,
    output logic [2:0]        ArfRegSel,
    output logic [1:0]        ArfOutCSel,
    output logic [1:0]        ArfOutDSel,
    output logic              ArfISel,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Done,
    output logic              Error,
    output logic [DepthW-1:0] Depth,
    // latched target, feeds the register file I-input mux when ArfISel = 0
    output logic [15:0]       TargetLatch
);

    localparam logic [2:0] cmd_fetch  = 3'b001;
    localparam logic [2:0] cmd_push   = 3'b010;
    localparam logic [2:0] cmd_pop    = 3'b011;
    localparam logic [2:0] cmd_call   = 3'b100;
    localparam logic [2:0] cmd_ret    = 3'b101;
    localparam logic [2:0] cmd_loadar = 3'b110;

    localparam logic [1:0] sel_pc = 2'b00;
    localparam logic [1:0] sel_ar = 2'b10;
    localparam logic [1:0] sel_sp = 2'b11;

    localparam logic [2:0] en_none = 3'b111;
    localparam logic [2:0] en_pc   = 3'b011;
    localparam logic [2:0] en_ar   = 3'b101;
    localparam logic [2:0] en_sp   = 3'b110;

    typedef enum logic [3:0] {
        st_idle,
        st_fetch,
        st_push_w,
        st_push_d,
        st_pop_i,
        st_pop_r,
        st_call_w,
        st_call_d,
        st_call_j,
        st_ret_i,
        st_ret_r,
        st_loadar,
        st_done
    } state_t;

    state_t             state;
    logic [DepthW-1:0]  depth_q;
    logic [15:0]        target_q;
    logic               err_q;
    logic               stack_full;
    logic               stack_empty;

    assign stack_full  = (depth_q == DepthW'(MaxDepth));
    assign stack_empty = (depth_q == '0);

    assign CmdReady    = (state == st_idle);
    assign Done        = (state == st_done);
    assign Error       = err_q;
    assign Depth       = depth_q;
    assign TargetLatch = target_q;

    // State sequencing, stack depth tracking, target latch and rejection pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= st_idle;
            depth_q  <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                st_idle: begin
                    if (CmdValid) begin
                        case (Cmd)
                            cmd_fetch: state <= st_fetch;
                            cmd_push: begin
                                if (stack_full) err_q <= 1'b1;
                                else            state <= st_push_w;
                            end
                            cmd_pop: begin
                                if (stack_empty) err_q <= 1'b1;
                                else             state <= st_pop_i;
                            end
                            cmd_call: begin
                                if (stack_full) begin
                                    err_q <= 1'b1;
                                end else begin
                                    target_q <= Target;
                                    state    <= st_call_w;
                                end
                            end
                            cmd_ret: begin
                                if (stack_empty) err_q <= 1'b1;
                                else             state <= st_ret_i;
                            end
                            cmd_loadar: begin
                                target_q <= Target;
                                state    <= st_loadar;
                            end
                            default: state <= st_idle;
                        endcase
                    end
                end
                st_fetch:  if (MemReady) state <= st_done;
                st_push_w: if (MemReady) state <= st_push_d;
                st_push_d: begin
                    depth_q <= depth_q + DepthW'(1);
                    state   <= st_done;
                end
                st_pop_i: begin
                    depth_q <= depth_q - DepthW'(1);
                    state   <= st_pop_r;
                end
                st_pop_r:  if (MemReady) state <= st_done;
                st_call_w: if (MemReady) state <= st_call_d;
                st_call_d: begin
                    depth_q <= depth_q + DepthW'(1);
                    state   <= st_call_j;
                end
                st_call_j: state <= st_done;
                st_ret_i: begin
                    depth_q <= depth_q - DepthW'(1);
                    state   <= st_ret_r;
                end
                st_ret_r:  if (MemReady) state <= st_done;
                st_loadar: state <= st_done;
                st_done:   state <= st_idle;
                default:   state <= st_idle;
            endcase
        end
    end

    // Register-file and memory controls decoded from the current state; the
    // register enable in the read/fetch states is qualified by MemReady so the
    // update lands only on the edge where memory completes.
    always_comb begin
        ArfRegSel  = en_none;
        ArfFunSel  = FsInc;
        ArfOutCSel = sel_pc;
        ArfOutDSel = sel_pc;
        ArfISel    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        case (state)
            st_fetch: begin
                ArfOutDSel = sel_pc;
                MemRead    = 1'b1;
                if (MemReady) begin
                    ArfRegSel = en_pc;
                    ArfFunSel = FsInc;
                end
            end
            st_push_w: begin
                ArfOutDSel = sel_sp;
                ArfOutCSel = sel_ar;
                MemWrite   = 1'b1;
            end
            st_push_d, st_call_d: begin
                ArfRegSel = en_sp;
                ArfFunSel = FsDec;
            end
            st_pop_i, st_ret_i: begin
                ArfRegSel = en_sp;
                ArfFunSel = FsInc;
            end
            st_pop_r: begin
                ArfOutDSel = sel_sp;
                MemRead    = 1'b1;
                if (MemReady) begin
                    ArfRegSel = en_ar;
                    ArfFunSel = FsLoad;
                    ArfISel   = 1'b1;
                end
            end
            st_call_w: begin
                ArfOutDSel = sel_sp;
                ArfOutCSel = sel_pc;
                MemWrite   = 1'b1;
            end
            st_call_j: begin
                ArfRegSel = en_pc;
                ArfFunSel = FsLoad;
                ArfISel   = 1'b0;
            end
            st_ret_r: begin
                ArfOutDSel = sel_sp;
                MemRead    = 1'b1;
                if (MemReady) begin
                    ArfRegSel = en_pc;
                    ArfFunSel = FsLoad;
                    ArfISel   = 1'b1;
                end
            end
            st_loadar: begin
                ArfRegSel = en_ar;
                ArfFunSel = FsLoad;
                ArfISel   = 1'b0;
            end
            default: begin
                ArfRegSel = en_none;
            end
        endcase
    end

endmodule
